bus_mux_arbiter: RTL and testbench

Parametrised, registered successor to the combinational encoder-plus-multiplexer bus. It selects one of N W-bit sources onto the shared bus from per-source out-enable strobes, under either fixed-priority or round-robin arbitration. It registers the bus value with one cycle of latency and flags multi-driver conflicts. It sits between the register file / special registers (HI, LO, Z, PC, MDR, InPort, C) and every bus consumer.

---
 rtl/bus_mux_arbiter.sv | 110 +++++++++++
 tb/tb_bus_mux_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mux_arbiter.sv
// Registered N-source bus multiplexer with fixed-priority or round-robin arbitration and conflict flagging.
// Define BUS_CONFLICT_CNT_EN to add the saturating conflict_cnt output and its cnt_clr input.
module bus_mux_arbiter #(
    parameter int N         = 32,
    parameter int W         = 32,
    parameter int RR_MODE   = 0,
    parameter int HOLD_IDLE = 1,
    localparam int IW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic [N-1:0]    src_en,
    input  logic [N*W-1:0]  src_data,
    input  logic            freeze,
`ifdef BUS_CONFLICT_CNT_EN
    input  logic            cnt_clr,
    output logic [15:0]     conflict_cnt,
`endif
    output logic [W-1:0]    bus_out,
    output logic            bus_valid,
    output logic [N-1:0]    grant,
    output logic [IW-1:0]   grant_idx,
    output logic            conflict
);

    logic [IW-1:0] rrPtr;
    logic [IW-1:0] winIdx;
    logic [W-1:0]  winData;
    logic          anyReq;
    logic          multiReq;
    logic          found;
    int            cand;

    assign anyReq   = |src_en;
    assign multiReq = |(src_en & (src_en - N'(1)));

    // Scan from the search start with wrap-around; the first asserted enable wins.
    always_comb begin
        winIdx = '0;
        found  = 1'b0;
        cand   = 0;
        for (int off = 0; off < N; off++) begin
            cand = int'(rrPtr) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && src_en[cand]) begin
                found  = 1'b1;
                winIdx = IW'(cand);
            end
        end
    end

    assign winData = src_data[int'(winIdx)*W +: W];

    if (RR_MODE != 0) begin : gRoundRobin
        logic [IW-1:0] nextPtr;

        assign nextPtr = (int'(winIdx) == N - 1) ? '0 : winIdx + IW'(1);

        always_ff @(posedge clk or negedge clr_n) begin
            if (!clr_n) begin
                rrPtr <= '0;
            end else if (!freeze && anyReq) begin
                rrPtr <= nextPtr;
            end
        end
    end else begin : gFixed
        assign rrPtr = '0;
    end

    // grant_idx deliberately survives idle cycles so the last winner stays visible.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            bus_out   <= '0;
            bus_valid <= 1'b0;
            grant     <= '0;
            grant_idx <= '0;
            conflict  <= 1'b0;
        end else if (!freeze) begin
            if (anyReq) begin
                bus_out   <= winData;
                bus_valid <= 1'b1;
                grant     <= N'(1) << winIdx;
                grant_idx <= winIdx;
                conflict  <= multiReq;
            end else begin
                bus_valid <= 1'b0;
                grant     <= '0;
                conflict  <= 1'b0;
                if (HOLD_IDLE == 0) begin
                    bus_out <= '0;
                end
            end
        end
    end

`ifdef BUS_CONFLICT_CNT_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            conflict_cnt <= '0;
        end else if (cnt_clr) begin
            conflict_cnt <= '0;
        end else if (!freeze && multiReq && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_mux_arbiter.sv
// Self-checking bench for bus_mux_arbiter: four configurations driven in parallel against a behavioural model.
// Build with BUS_CONFLICT_CNT_EN defined to also exercise the conflict counter.
module tb_bus_mux_arbiter;

    localparam int CLK_HALF = 5;
    localparam int NI = 4;
    localparam int CFG_N    [NI] = '{32, 32, 8, 5};
    localparam int CFG_W    [NI] = '{32, 32, 16, 8};
    localparam int CFG_RR   [NI] = '{0, 1, 0, 1};
    localparam int CFG_HOLD [NI] = '{1, 1, 0, 0};

    logic        clk = 1'b0;
    logic        clr_n;
    logic [31:0] srcEn;
    logic [31:0] srcData [32];
    logic        freeze;
    logic        cntClr;
    bit          checking = 1'b0;

    int tests = 0;
    int fails = 0;

    logic [31:0] dBus   [NI];
    logic [31:0] dValid [NI];
    logic [31:0] dGrant [NI];
    logic [31:0] dIdx   [NI];
    logic [31:0] dConf  [NI];
    logic [31:0] dCnt   [NI];

    logic [31:0] mBus   [NI] = '{default: 32'd0};
    bit          mValid [NI] = '{default: 1'b0};
    logic [31:0] mGrant [NI] = '{default: 32'd0};
    int          mIdx   [NI] = '{default: 0};
    bit          mConf  [NI] = '{default: 1'b0};
    int          mPtr   [NI] = '{default: 0};
    int          mCnt   [NI] = '{default: 0};

    always #CLK_HALF clk = ~clk;

    // One DUT per configuration, all sharing the same stimulus (upper enable bits are cut off by N).
    for (genvar k = 0; k < NI; k++) begin : gDut
        localparam int NK  = CFG_N[k];
        localparam int WK  = CFG_W[k];
        localparam int IWK = $clog2(NK);

        logic [NK*WK-1:0] flat;
        logic [WK-1:0]    busO;
        logic             busV;
        logic [NK-1:0]    gr;
        logic [IWK-1:0]   gi;
        logic             cf;

        for (genvar i = 0; i < NK; i++) begin : gData
            assign flat[i*WK +: WK] = srcData[i][WK-1:0];
        end

`ifdef BUS_CONFLICT_CNT_EN
        logic [15:0] cnt;
        assign dCnt[k] = 32'(cnt);
`else
        assign dCnt[k] = 32'd0;
`endif

        bus_mux_arbiter #(
            .N(NK), .W(WK), .RR_MODE(CFG_RR[k]), .HOLD_IDLE(CFG_HOLD[k])
        ) u (
            .clk(clk),
            .clr_n(clr_n),
            .src_en(srcEn[NK-1:0]),
            .src_data(flat),
            .freeze(freeze),
`ifdef BUS_CONFLICT_CNT_EN
            .cnt_clr(cntClr),
            .conflict_cnt(cnt),
`endif
            .bus_out(busO),
            .bus_valid(busV),
            .grant(gr),
            .grant_idx(gi),
            .conflict(cf)
        );

        assign dBus[k]   = 32'(busO);
        assign dValid[k] = 32'(busV);
        assign dGrant[k] = 32'(gr);
        assign dIdx[k]   = 32'(gi);
        assign dConf[k]  = 32'(cf);
    end

    function automatic logic [31:0] wMask(input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return m[31:0];
    endfunction

    // Reference behaviour: count requests, search for the winner from the pointer, update outputs.
    task automatic modelStep(input int k);
        int n;
        int reqs;
        int winner;
        int cand;
        n      = CFG_N[k];
        reqs   = 0;
        winner = -1;
        for (int i = 0; i < n; i++) begin
            if (srcEn[i]) reqs++;
        end
        if (cntClr) mCnt[k] = 0;
        else if (!freeze && reqs > 1 && mCnt[k] < 65535) mCnt[k]++;
        if (freeze) return;
        for (int off = 0; off < n; off++) begin
            cand = (mPtr[k] + off) % n;
            if (winner < 0 && srcEn[cand]) winner = cand;
        end
        if (winner >= 0) begin
            mBus[k]   = srcData[winner] & wMask(CFG_W[k]);
            mGrant[k] = 32'd1 << winner;
            mIdx[k]   = winner;
            mValid[k] = 1'b1;
            mConf[k]  = (reqs > 1);
            if (CFG_RR[k] != 0) mPtr[k] = (winner + 1) % n;
        end else begin
            mGrant[k] = 32'd0;
            mValid[k] = 1'b0;
            mConf[k]  = 1'b0;
            if (CFG_HOLD[k] == 0) mBus[k] = 32'd0;
        end
    endtask

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int k = 0; k < NI; k++) begin
                mBus[k] = 0; mValid[k] = 0; mGrant[k] = 0; mIdx[k] = 0;
                mConf[k] = 0; mPtr[k] = 0; mCnt[k] = 0;
            end
        end else begin
            for (int k = 0; k < NI; k++) modelStep(k);
        end
    end

    task automatic checkOutput(input string what, input int k, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (k >= 0) $display("[TB] FAIL u%0d %s: got %h, expected %h at %0t", k, what, act, exp, $time);
            else        $display("[TB] FAIL %s: got %h, expected %h at %0t", what, act, exp, $time);
        end
    endtask

    // Every falling edge, every configuration is compared against the model.
    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < NI; k++) begin
                checkOutput("bus_out",   k, dBus[k],   mBus[k]);
                checkOutput("bus_valid", k, dValid[k], 32'(mValid[k]));
                checkOutput("grant",     k, dGrant[k], mGrant[k]);
                checkOutput("grant_idx", k, dIdx[k],   32'(mIdx[k]));
                checkOutput("conflict",  k, dConf[k],  32'(mConf[k]));
`ifdef BUS_CONFLICT_CNT_EN
                checkOutput("conflict_cnt", k, dCnt[k], 32'(mCnt[k]));
`endif
            end
        end
    end

    task automatic applyStimulus();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0, 1:    srcEn = 32'd0;
            2, 3, 4: srcEn = 32'd1 << $urandom_range(0, 31);
            5, 6:    srcEn = $urandom & 32'h0000_00FF;
            7:       srcEn = $urandom & 32'h0000_001F;
            default: srcEn = $urandom;
        endcase
        for (int i = 0; i < 32; i++) srcData[i] = $urandom;
        freeze = ($urandom_range(0, 9) == 0);
        cntClr = ($urandom_range(0, 19) == 0);
    endtask

    initial begin
        #(CLK_HALF * 2 * 200000);
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clr_n  = 1'b0;
        srcEn  = 32'd0;
        freeze = 1'b0;
        cntClr = 1'b0;
        for (int i = 0; i < 32; i++) srcData[i] = 32'd0;
        repeat (2) @(negedge clk);
        checking = 1'b1;
        clr_n = 1'b1;
        checkOutput("reset bus_out", -1, dBus[0], 32'd0);
        checkOutput("reset bus_valid", -1, dValid[1], 32'd0);

        // Asynchronous reset lands mid-cycle and must clear outputs before the next edge.
        srcData[5] = 32'hDEADBEEF;
        srcEn = 32'd1 << 5;
        repeat (3) @(negedge clk);
        checkOutput("t1 bus before reset", -1, dBus[0], 32'hDEADBEEF);
        @(posedge clk);
        #2 clr_n = 1'b0;
        #1;
        checkOutput("t1 async bus_out", -1, dBus[0], 32'd0);
        checkOutput("t1 async grant", -1, dGrant[0], 32'd0);
        checkOutput("t1 async bus_valid", -1, dValid[0], 32'd0);
        @(negedge clk);
        srcEn = 32'd0;
        clr_n = 1'b1;

        srcData[20] = 32'h00000104;
        srcEn = 32'd1 << 20;
        @(negedge clk);
        checkOutput("t2 bus_out", -1, dBus[0], 32'h00000104);
        checkOutput("t2 grant_idx", -1, dIdx[0], 32'd20);
        checkOutput("t2 bus_valid", -1, dValid[0], 32'd1);
        checkOutput("t2 conflict", -1, dConf[0], 32'd0);
        srcEn = 32'd0;
        @(negedge clk);
        checkOutput("t2 idle bus_out", -1, dBus[0], 32'h00000104);
        checkOutput("t2 idle bus_valid", -1, dValid[0], 32'd0);
        checkOutput("t2 idle grant", -1, dGrant[0], 32'd0);

        srcData[3]  = 32'h11;
        srcData[17] = 32'h22;
        srcEn = (32'd1 << 3) | (32'd1 << 17);
        @(negedge clk);
        checkOutput("t3 bus_out", -1, dBus[0], 32'h11);
        checkOutput("t3 grant_idx", -1, dIdx[0], 32'd3);
        checkOutput("t3 conflict", -1, dConf[0], 32'd1);
`ifdef BUS_CONFLICT_CNT_EN
        checkOutput("t3 conflict_cnt", -1, dCnt[0], 32'd1);
`endif
        srcEn = 32'd0;

        // Short reset pulse between edges so the round-robin pointer restarts at 0.
        #1 clr_n = 1'b0;
        #1 clr_n = 1'b1;
        srcData[0]  = 32'h00001234;
        srcData[31] = 32'h31313131;
        srcEn = 32'd1 | (32'd1 << 31);
        begin
            int rrSeq [4] = '{0, 31, 0, 31};
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                checkOutput($sformatf("t4 rr grant_idx step %0d", j), -1, dIdx[1], 32'(rrSeq[j]));
            end
        end

        srcData[7] = 32'hA5A5A5A5;
        srcEn = 32'd1 << 7;
        freeze = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("t5 frozen bus_out", -1, dBus[0], 32'h00001234);
        checkOutput("t5 frozen grant", -1, dGrant[0], 32'd1);
        checkOutput("t5 frozen rr grant_idx", -1, dIdx[1], 32'd31);
        freeze = 1'b0;
        @(negedge clk);
        checkOutput("t5 thawed bus_out", -1, dBus[0], 32'hA5A5A5A5);
        checkOutput("t5 thawed rr grant_idx", -1, dIdx[1], 32'd7);

        srcData[2] = 32'h0000BEEF;
        srcEn = 32'd1 << 2;
        @(negedge clk);
        checkOutput("t6 narrow bus_out", -1, dBus[2], 32'h0000BEEF);
        srcEn = 32'd0;
        @(negedge clk);
        checkOutput("t6 narrow idle bus_out", -1, dBus[2], 32'h00000000);
        checkOutput("t6 wide idle bus_out", -1, dBus[0], 32'h0000BEEF);

`ifdef BUS_CONFLICT_CNT_EN
        cntClr = 1'b1;
        @(negedge clk);
        checkOutput("t6 cnt cleared", -1, dCnt[2], 32'd0);
        cntClr = 1'b0;
        srcEn = 32'h3;
        repeat (65535) @(negedge clk);
        checkOutput("t6 cnt full", -1, dCnt[2], 32'h0000FFFF);
        @(negedge clk);
        checkOutput("t6 cnt saturated", -1, dCnt[2], 32'h0000FFFF);
        freeze = 1'b1;
        cntClr = 1'b1;
        @(negedge clk);
        checkOutput("t6 cnt clear while frozen", -1, dCnt[2], 32'd0);
        freeze = 1'b0;
        cntClr = 1'b0;
`endif

        for (int c = 0; c < 3000; c++) begin
            applyStimulus();
            if ($urandom_range(0, 99) == 0) begin
                #2 clr_n = 1'b0;
            end
            @(negedge clk);
            clr_n = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
